// File: rtl/capture_pkg.sv
// Shared constants for the OV7670 capture path (capturer, capture_ctrl, VGA reader).
// Holds the sequencer state encoding and the 160x120 RGB332 frame geometry.
package capture_pkg;

  localparam int unsigned HRes          = 160;
  localparam int unsigned VRes          = 120;
  localparam int unsigned Rgb332Width   = 8;
  localparam int unsigned DefaultPixels = HRes * VRes;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StArm  = 3'd1,
    StSync = 3'd2,
    StCap  = 3'd3,
    StDone = 3'd4
  } cap_state_e;

endpackage

// File: rtl/vsync_edge.sv
// VSYNC edge detector for the capture sequencer.
// Ports:
//   PCLK    - camera pixel clock
//   rst     - synchronous active-high reset
//   VSYNC   - camera VSYNC, high between frames
//   vs_rise - VSYNC went 0->1 this cycle (frame end)
//   vs_fall - VSYNC went 1->0 this cycle (frame start)
module vsync_edge (
  input  logic PCLK,
  input  logic rst,
  input  logic VSYNC,
  output logic vs_rise,
  output logic vs_fall
);

  logic vsync_q;

  // Resets high so a VSYNC already high at reset does not look like a rising edge.
  always_ff @(posedge PCLK) begin
    if (rst) begin
      vsync_q <= 1'b1;
    end else begin
      vsync_q <= VSYNC;
    end
  end

  assign vs_rise = VSYNC & ~vsync_q;
  assign vs_fall = ~VSYNC & vsync_q;

endmodule

// File: rtl/capture_ctrl.sv
// Frame-level sequencer between the OV7670 pixel capturer and the frame-buffer write port.
// Starts single or continuous captures on command, aligns them to VSYNC, gates the capturer's
// write strobe, counts pixels per frame and flags short/long frames.
// Optional watchdog: define CAPTURE_CTRL_TIMEOUT_EN to add TIMEOUT_CYCLES and err_timeout.
// Ports:
//   PCLK, rst          - pixel clock, synchronous active-high reset
//   VSYNC              - camera VSYNC (high between frames)
//   cmd_single/cont/stop - one-cycle command pulses
//   cap_wr             - capturer write strobe
//   mem_we             - gated RAM write enable
//   busy, frame_done   - not idle; one-cycle end-of-frame pulse
//   frame_cnt          - completed frames (wraps)
//   err_short/err_long - sticky frame size errors
//   err_timeout        - sticky watchdog error (only with CAPTURE_CTRL_TIMEOUT_EN)
module capture_ctrl import capture_pkg::*; #(
  parameter int unsigned PIXELS = DefaultPixels,
  parameter int unsigned CNT_W  = 15
`ifdef CAPTURE_CTRL_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
`endif
) (
  input  logic       PCLK,
  input  logic       rst,
  input  logic       VSYNC,
  input  logic       cmd_single,
  input  logic       cmd_cont,
  input  logic       cmd_stop,
  input  logic       cap_wr,
  output logic       mem_we,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_cnt,
  output logic       err_short,
  output logic       err_long
`ifdef CAPTURE_CTRL_TIMEOUT_EN
  ,
  output logic       err_timeout
`endif
);

  localparam logic [CNT_W-1:0] PixTarget = CNT_W'(PIXELS);

  cap_state_e       state_q, state_d;
  logic             wr_gate_q, wr_gate_d;
  logic             mode_cont_q, mode_cont_d;
  logic             stop_req_q, stop_req_d;
  logic             err_short_q, err_short_d;
  logic             err_long_q, err_long_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  logic             cap_wr_q;
  logic             vs_rise, vs_fall;
  logic             wr_rise, overflow;

  vsync_edge u_vsync_edge (
    .PCLK    (PCLK),
    .rst     (rst),
    .VSYNC   (VSYNC),
    .vs_rise (vs_rise),
    .vs_fall (vs_fall)
  );

  assign wr_rise  = cap_wr & ~cap_wr_q;
  // Blocks the extra write in the very cycle it appears so the address never wraps.
  assign overflow = (state_q == StCap) & wr_rise & (pix_cnt_q == PixTarget);
  assign mem_we   = cap_wr & wr_gate_q & ~overflow & ~rst;

`ifdef CAPTURE_CTRL_TIMEOUT_EN
  localparam int unsigned WdogW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             err_timeout_q, err_timeout_d;
  logic             active;
`endif

  always_comb begin
    state_d     = state_q;
    wr_gate_d   = wr_gate_q;
    mode_cont_d = mode_cont_q;
    stop_req_d  = stop_req_q;
    err_short_d = err_short_q;
    err_long_d  = err_long_q;
    pix_cnt_d   = pix_cnt_q;
    frame_cnt_d = frame_cnt_q;
    frame_done  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Stop outranks the start commands even though it has no effect here.
        if (!cmd_stop && (cmd_single || cmd_cont)) begin
          state_d     = StArm;
          mode_cont_d = ~cmd_single;
          err_short_d = 1'b0;
          err_long_d  = 1'b0;
          stop_req_d  = 1'b0;
        end
      end
      StArm: begin
        if (cmd_stop) begin
          state_d = StIdle;
        end else if (VSYNC) begin
          state_d = StSync;
        end
      end
      StSync: begin
        if (cmd_stop) begin
          state_d = StIdle;
        end else if (vs_fall) begin
          state_d   = StCap;
          wr_gate_d = 1'b1;
          pix_cnt_d = '0;
        end
      end
      StCap: begin
        if (cmd_stop) begin
          stop_req_d = 1'b1;
        end
        if (wr_rise) begin
          if (pix_cnt_q == PixTarget) begin
            wr_gate_d  = 1'b0;
            err_long_d = 1'b1;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end
        if (vs_rise) begin
          state_d   = StDone;
          wr_gate_d = 1'b0;
        end
      end
      StDone: begin
        frame_done  = 1'b1;
        frame_cnt_d = frame_cnt_q + 8'd1;
        if (pix_cnt_q < PixTarget) begin
          err_short_d = 1'b1;
        end
        if (mode_cont_q && !stop_req_q && !cmd_stop) begin
          state_d = StSync;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d   = StIdle;
        wr_gate_d = 1'b0;
      end
    endcase

`ifdef CAPTURE_CTRL_TIMEOUT_EN
    active        = (state_q == StArm) || (state_q == StSync) || (state_q == StCap);
    err_timeout_d = err_timeout_q;
    if (active && (wdog_q == WdogW'(TIMEOUT_CYCLES - 1))) begin
      state_d       = StIdle;
      wr_gate_d     = 1'b0;
      err_timeout_d = 1'b1;
    end
    if ((state_q == StIdle) && (state_d == StArm)) begin
      err_timeout_d = 1'b0;
    end
    if (state_d != state_q || !active) begin
      wdog_d = '0;
    end else begin
      wdog_d = wdog_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge PCLK) begin
    if (rst) begin
      state_q     <= StIdle;
      wr_gate_q   <= 1'b0;
      mode_cont_q <= 1'b0;
      stop_req_q  <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      pix_cnt_q   <= '0;
      frame_cnt_q <= '0;
      cap_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_gate_q   <= wr_gate_d;
      mode_cont_q <= mode_cont_d;
      stop_req_q  <= stop_req_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      pix_cnt_q   <= pix_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      cap_wr_q    <= cap_wr;
    end
  end

`ifdef CAPTURE_CTRL_TIMEOUT_EN
  always_ff @(posedge PCLK) begin
    if (rst) begin
      wdog_q        <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      wdog_q        <= wdog_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout = err_timeout_q;
`endif

  assign busy      = (state_q != StIdle);
  assign frame_cnt = frame_cnt_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl with PIXELS=16.
// Each frame pushes its expected result to a scoreboard queue; it is popped once the DUT
// signals frame_done. Inputs are driven 1 time unit after posedge; outputs sampled on negedge.
module tb_capture_ctrl;

  logic       PCLK = 1'b0;
  logic       rst;
  logic       VSYNC;
  logic       cmd_single;
  logic       cmd_cont;
  logic       cmd_stop;
  logic       cap_wr;
  logic       mem_we;
  logic       busy;
  logic       frame_done;
  logic [7:0] frame_cnt;
  logic       err_short;
  logic       err_long;
`ifdef CAPTURE_CTRL_TIMEOUT_EN
  logic       err_timeout;
`endif

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  logic [7:0] exp_fc = 8'd0;

  typedef struct {
    logic [7:0] fc;
    logic       es;
    logic       el;
    int         we;
  } exp_t;

  exp_t exp_q[$];

  always #5 PCLK = ~PCLK;

  capture_ctrl #(
    .PIXELS (16),
    .CNT_W  (5)
`ifdef CAPTURE_CTRL_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (100)
`endif
  ) dut (
    .PCLK       (PCLK),
    .rst        (rst),
    .VSYNC      (VSYNC),
    .cmd_single (cmd_single),
    .cmd_cont   (cmd_cont),
    .cmd_stop   (cmd_stop),
    .cap_wr     (cap_wr),
    .mem_we     (mem_we),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .err_short  (err_short),
    .err_long   (err_long)
`ifdef CAPTURE_CTRL_TIMEOUT_EN
    ,
    .err_timeout (err_timeout)
`endif
  );

  // Counts write-enable cycles that reach the RAM.
  always @(negedge PCLK) begin
    if (mem_we === 1'b1) we_cnt <= we_cnt + 1;
  end

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic start_cmd(input bit cont);
    step();
    cmd_single = ~cont;
    cmd_cont   = cont;
    step();
    cmd_single = 1'b0;
    cmd_cont   = 1'b0;
    step();
  endtask

  // One frame: VSYNC low, n one-cycle write pulses, VSYNC high; stop pulse with pulse stop_at.
  task automatic run_frame(input int n, input int stop_at, input logic es, input logic el,
                           input int we_exp, input string name);
    exp_t e;
    int   base;
    bit   seen;
    exp_fc = exp_fc + 8'd1;
    e.fc = exp_fc;
    e.es = es;
    e.el = el;
    e.we = we_exp;
    exp_q.push_back(e);
    base = we_cnt;
    step();
    VSYNC = 1'b0;
    step();
    step();
    for (int i = 0; i < n; i++) begin
      cap_wr   = 1'b1;
      cmd_stop = (i == stop_at);
      step();
      cap_wr   = 1'b0;
      cmd_stop = 1'b0;
      step();
    end
    VSYNC = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge PCLK);
      if (frame_done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s frame_done: got none within 8 cycles, required one pulse", name);
    end
    @(negedge PCLK);
    e = exp_q.pop_front();
    checks++;
    if (frame_cnt !== e.fc) begin
      errors++;
      $display("FAIL %s frame_cnt: got %0d required %0d", name, frame_cnt, e.fc);
    end
    checks++;
    if (err_short !== e.es) begin
      errors++;
      $display("FAIL %s err_short: got %b required %b", name, err_short, e.es);
    end
    checks++;
    if (err_long !== e.el) begin
      errors++;
      $display("FAIL %s err_long: got %b required %b", name, err_long, e.el);
    end
    checks++;
    if (we_cnt - base !== e.we) begin
      errors++;
      $display("FAIL %s mem_we count: got %0d required %0d", name, we_cnt - base, e.we);
    end
  endtask

  task automatic check_bit(input logic got, input logic req, input string name);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, got, req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    VSYNC = 1'b1;
    cmd_single = 1'b0;
    cmd_cont = 1'b0;
    cmd_stop = 1'b0;
    cap_wr = 1'b1;
    repeat (3) step();
    @(negedge PCLK);
    check_bit(mem_we, 1'b0, "reset mem_we");
    check_bit(busy, 1'b0, "reset busy");
    check_bit(frame_done, 1'b0, "reset frame_done");
    check_bit(err_short, 1'b0, "reset err_short");
    check_bit(err_long, 1'b0, "reset err_long");
    checks++;
    if (frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset frame_cnt: got %0d required 0", frame_cnt);
    end
`ifdef CAPTURE_CTRL_TIMEOUT_EN
    check_bit(err_timeout, 1'b0, "reset err_timeout");
`endif
    step();
    cap_wr = 1'b0;
    rst = 1'b0;
    exp_fc = 8'd0;
  endtask

  task automatic test_single();
    start_cmd(1'b0);
    @(negedge PCLK);
    check_bit(busy, 1'b1, "single busy");
    run_frame(16, -1, 1'b0, 1'b0, 16, "single");
    check_bit(busy, 1'b0, "single idle after");
  endtask

  task automatic test_back_to_back();
    start_cmd(1'b1);
    run_frame(16, -1, 1'b0, 1'b0, 16, "cont f1");
    run_frame(16, -1, 1'b0, 1'b0, 16, "cont f2");
    check_bit(busy, 1'b1, "cont busy between frames");
    run_frame(16, 7, 1'b0, 1'b0, 16, "cont f3 stop");
    check_bit(busy, 1'b0, "cont idle after stop");
  endtask

  task automatic test_short();
    start_cmd(1'b0);
    run_frame(12, -1, 1'b1, 1'b0, 12, "short");
    step();
    cmd_single = 1'b1;
    step();
    cmd_single = 1'b0;
    @(negedge PCLK);
    check_bit(err_short, 1'b0, "short cleared by cmd_single");
    check_bit(busy, 1'b1, "short rearmed busy");
    step();
    cmd_stop = 1'b1;
    step();
    cmd_stop = 1'b0;
    @(negedge PCLK);
    check_bit(busy, 1'b0, "stop before frame start");
  endtask

  task automatic test_long();
    start_cmd(1'b0);
    run_frame(20, -1, 1'b0, 1'b1, 16, "long");
  endtask

  task automatic test_idle_gating();
    for (int i = 0; i < 3; i++) begin
      step();
      cap_wr = 1'b1;
      @(negedge PCLK);
      check_bit(mem_we, 1'b0, "idle write gated");
      step();
      cap_wr = 1'b0;
    end
    start_cmd(1'b0);
    cap_wr = 1'b1;
    @(negedge PCLK);
    check_bit(mem_we, 1'b0, "armed write gated");
    step();
    cap_wr = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    step();
    VSYNC = 1'b0;
    step();
    step();
    cap_wr = 1'b1;
    @(negedge PCLK);
    check_bit(mem_we, 1'b1, "capture write passes");
    step();
    cap_wr = 1'b0;
    step();
    cap_wr = 1'b1;
    rst = 1'b1;
    @(negedge PCLK);
    check_bit(mem_we, 1'b0, "rst cycle mem_we");
    step();
    rst = 1'b0;
    cap_wr = 1'b0;
    VSYNC = 1'b1;
    exp_fc = 8'd0;
    @(negedge PCLK);
    check_bit(busy, 1'b0, "post rst busy");
    check_bit(frame_done, 1'b0, "post rst frame_done");
    check_bit(err_short, 1'b0, "post rst err_short");
    check_bit(err_long, 1'b0, "post rst err_long");
    checks++;
    if (frame_cnt !== exp_fc) begin
      errors++;
      $display("FAIL post rst frame_cnt: got %0d required %0d", frame_cnt, exp_fc);
    end
  endtask

`ifdef CAPTURE_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    step();
    VSYNC = 1'b0;
    step();
    cmd_single = 1'b1;
    step();
    cmd_single = 1'b0;
    repeat (90) step();
    @(negedge PCLK);
    check_bit(busy, 1'b1, "timeout still waiting");
    repeat (15) step();
    @(negedge PCLK);
    check_bit(busy, 1'b0, "timeout forced idle");
    check_bit(err_timeout, 1'b1, "timeout err_timeout");
    VSYNC = 1'b1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global time limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_short();
    test_long();
    test_idle_gating();
    test_reset_mid_frame();
`ifdef CAPTURE_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending frames, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
